// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters. One transaction
// is in flight at a time: IDLE (grant) -> EXEC (ALU evaluates) -> RESP (hold result).
module alu_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 5
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_opA,
    input  logic [WIDTH-1:0] req0_opB,
    input  logic [OPW-1:0]   req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_opA,
    input  logic [WIDTH-1:0] req1_opB,
    input  logic [OPW-1:0]   req1_op,

    output logic [WIDTH-1:0] alu_opA,
    output logic [WIDTH-1:0] alu_opB,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;

    logic grant0, grant1;
    logic op_legal;

    // Round-robin grant: on a tie the requester not granted last wins.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant_q);
        grant1     = req1_valid & (~req0_valid | ~last_grant_q);
        req0_ready = (state_q == StIdle) & grant0;
        req1_ready = (state_q == StIdle) & grant1;
    end

    // Decode the registered opcode against the supported ALU operations.
    always_comb begin
        op_legal = 1'b0;
        case (op_q)
            5'b00000, 5'b00010, 5'b00110,
            5'b00100, 5'b01100, 5'b01110: op_legal = 1'b1;
            default:                      op_legal = 1'b0;
        endcase
    end

    // Next-state: capture the granted request, then the ALU outcome, then hold.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            StIdle: begin
                if (grant0 | grant1) begin
                    opa_d        = grant1 ? req1_opA : req0_opA;
                    opb_d        = grant1 ? req1_opB : req0_opB;
                    op_d         = grant1 ? req1_op  : req0_op;
                    id_d         = grant1;
                    last_grant_d = grant1;
                    state_d      = StExec;
                end
            end
            StExec: begin
                // Illegal opcodes still spend the EXEC cycle but discard the ALU output.
                rsp_result_d = op_legal ? alu_result : '0;
                rsp_zero_d   = op_legal & alu_zero;
                rsp_err_d    = ~op_legal;
                state_d      = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; last_grant resets to 1 so req0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            opa_q        <= '0;
            opb_q        <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // ALU and response ports are driven only from registers.
    always_comb begin
        alu_opA    = opa_q;
        alu_opB    = opb_q;
        alu_op     = op_q;
        rsp_valid  = (state_q == StResp);
        rsp_id     = id_q;
        rsp_result = rsp_result_q;
        rsp_zero   = rsp_zero_q;
        rsp_err    = rsp_err_q;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit ALU between two requesters, such as an integer issue path and a branch/address unit. Each requester presents an operand pair and a 5-bit ALU opcode with a valid/ready handshake. The block grants the ALU round-robin, registers the operands, drives the ALU for one execute cycle and captures the result. It returns the result to a single response port tagged with the requester id. Only one transaction is in flight at a time.

## Interface
- WIDTH, 32, operand/result width.
- OPW, 5, ALU opcode width.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a transaction.
- req0_ready  out  1  requester 0 transaction accepted this cycle.
- req0_opA, req0_opB  in  WIDTH  requester 0 operands.
- req0_op  in  OPW  requester 0 ALU opcode.
- req1_valid, req1_ready, req1_opA, req1_opB, req1_op: same as requester 0, for requester 1.
- alu_opA, alu_opB  out  WIDTH  operands to the shared ALU.
- alu_op  out  OPW  opcode to the shared ALU.
- alu_result  in  WIDTH  ALU result (combinational from alu_* outputs).
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the response.
- rsp_result  out  WIDTH  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_err  out  1  opcode was illegal; ALU result not used.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant when any reqN_valid is high.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester not granted last (last_grant pointer) is granted.
  - reqN_ready = (state==IDLE) & grantN. It is combinational from valid and never high for both requesters.
  - On grant: register opA, opB, op and id; set last_grant = id; go to EXEC.
- **EXEC**
  - alu_opA/opB/op are driven from the operand registers. They are driven from registers in every state, so there is no glitch path from the request ports.
  - At the clock edge: capture rsp_result = alu_result and rsp_zero = alu_zero; go to RESP.
- **Legal opcodes**: 00000 AND, 00010 OR, 00110 XOR, 00100 ADD, 01100 SUB, 01110 SLT.
  - Any other opcode: rsp_err = 1, rsp_result = 0, rsp_zero = 0. The FSM still passes through EXEC, so latency is unchanged.
- **RESP**
  - rsp_valid = 1. rsp_id, rsp_result, rsp_zero and rsp_err are held stable until rsp_valid & rsp_ready.
  - On handshake: go to IDLE.
  - No request is accepted in EXEC or RESP; both reqN_ready are 0.
- **Requester rules**: keep valid high and operands/opcode stable until ready. Dropping valid before ready is allowed; the request is then lost, with no error.

## Timing
- **Reset values**: state = IDLE, last_grant = 1 (requester 0 wins the first tie), all operand/response registers = 0.
  - Outputs after reset: alu_opA = alu_opB = 0, alu_op = 00000, rsp_* = 0, reqN_ready = 0 unless a request is valid in IDLE.
- **Latency**: accept at edge T (ready high in the cycle before edge T). rsp_valid rises after edge T+1, i.e. it is visible in cycle T+1 and sampled at edge T+2.
- **Throughput**: with rsp_ready tied high, the minimum is one transaction per 3 cycles (IDLE, EXEC, RESP).
- A response handshake and the next grant never occur in the same cycle. The next grant happens in IDLE, the cycle after the handshake.
- **Back-pressure**: RESP persists any number of cycles. The response is held with no change, and no request is accepted meanwhile.
- **Reset mid-operation** (EXEC or RESP): the transaction is discarded, no response is issued, and the FSM and last_grant return to their reset values on the next edge.
- **Arithmetic**: the block performs none. Width and signedness of results are the ALU's; SLT results are passed through unmodified.

## Test plan
- **Single request**: req0 ADD opA = 5, opB = 3 after reset.
  - req0_ready for 1 cycle.
  - rsp_valid 2 cycles later with rsp_id = 0, rsp_result = 8, rsp_zero = 0, rsp_err = 0.
- **Contention**: req0 and req1 both valid continuously after reset (req0 AND 0xF0 & 0x3C, req1 OR 0xF0 | 0x0F).
  - Grants alternate 0, 1, 0, 1.
  - Responses: id0 = 0x30, id1 = 0xFF.
  - ready is never high on both ports.
- **Zero flag and SLT**:
  - req1 SUB 7 − 7: result 0, rsp_zero = 1.
  - req1 SLT 2 < 9: result 1, rsp_zero = 0.
- **Illegal opcode**: req0 op = 11111.
  - rsp_err = 1, rsp_result = 0, rsp_zero = 0, same 2-cycle latency.
  - The next legal request behaves normally.
- **Back-pressure**: rsp_ready held low 4 cycles while req1 stays valid.
  - rsp_* stable throughout; req1_ready = 0.
  - After the handshake, req1 is granted in the next IDLE cycle.
- **Reset mid-operation**: reset asserted in EXEC.
  - No rsp_valid ever appears for that transaction.
  - With both requesters valid after reset, req0 is granted first.
